// File: rtl/shuffle_sched_if.sv
// Handshake and schedule bundle between the FFT front end and the shuffler sequencer.
// master = frame requester / observer, slave = the sequencing controller.
interface shuffle_sched_if #(
    parameter int NUM_STAGES = 3
);
    logic                  start;
    logic                  in_take;
    logic [NUM_STAGES-1:0] sel;
    logic                  out_valid;
    logic                  out_sof;
    logic                  done;
    logic                  busy;

    modport master (
        output start,
        input  in_take, sel, out_valid, out_sof, done, busy
    );

    modport slave (
        input  start,
        output in_take, sel, out_valid, out_sof, done, busy
    );
endinterface

// File: rtl/shuffle_sched_ctrl.sv
// Sequencer for a cascade of basic_shuffler stages: frame counter, per-stage sel
// schedule aligned to data arrival, and output framing at the end of the cascade.
module shuffle_sched_ctrl #(
    parameter int LOG_N      = 4,
    parameter int NUM_STAGES = 3,
    parameter int STAGE_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    shuffle_sched_if.slave    bus
);
    localparam int L_TOT = NUM_STAGES * STAGE_LAT;
    localparam logic [LOG_N-1:0] LAST = '1;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic             valid;
        logic             sof;
        logic [LOG_N-1:0] cnt;
    } tag_t;

    state_t           state, state_nxt;
    logic [LOG_N-1:0] cnt, cnt_nxt;
    tag_t             line [1:L_TOT];
    tag_t             tap  [0:L_TOT];
    logic [NUM_STAGES-1:0] sel_q, sel_d;
    logic             run;

    assign run = (state == RUN);

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = bus.start ? RUN : IDLE;
                end else begin
                    cnt_nxt = cnt + LOG_N'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // tap[d] is the tag of the sample that entered d cycles ago; tap[0] is live.
    always_comb begin
        tap[0] = '{valid: run, sof: run && (cnt == '0), cnt: cnt};
        for (int i = 1; i <= L_TOT; i++) tap[i] = line[i];
    end

    // Each sel is registered one tap early so it lines up with data at its stage.
    assign sel_d[0] = (state_nxt == RUN) && cnt_nxt[LOG_N-1];
    for (genvar k = 1; k < NUM_STAGES; k++) begin : g_sel
        assign sel_d[k] = tap[k*STAGE_LAT-1].valid && tap[k*STAGE_LAT-1].cnt[LOG_N-1-k];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the tag line is reset too, because a reset must drop every in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sel_q <= '0;
            for (int i = 1; i <= L_TOT; i++) line[i] <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel_q <= sel_d;
            for (int i = 1; i <= L_TOT; i++) line[i] <= tap[i-1];
        end
    end

    always_comb begin
        bus.busy = run;
        for (int i = 1; i <= L_TOT; i++) bus.busy = bus.busy | line[i].valid;
    end

    assign bus.in_take   = run;
    assign bus.sel       = sel_q;
    assign bus.out_valid = line[L_TOT].valid;
    assign bus.out_sof   = line[L_TOT].valid && line[L_TOT].sof;
    assign bus.done      = line[L_TOT].valid && (line[L_TOT].cnt == LAST);
endmodule

// File: tb/tb_shuffle_sched_ctrl.sv
// Randomized bench for shuffle_sched_ctrl: default build plus a small build
// (LOG_N=2, 2 stages, latency 1), both checked against a sample-history model.
module tb_shuffle_sched_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    shuffle_sched_if #(.NUM_STAGES(3)) bus_a ();
    shuffle_sched_if #(.NUM_STAGES(2)) bus_b ();

    assign bus_a.start = start;
    assign bus_b.start = start;

    shuffle_sched_ctrl #(.LOG_N(4), .NUM_STAGES(3), .STAGE_LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    shuffle_sched_ctrl #(.LOG_N(2), .NUM_STAGES(2), .STAGE_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Model: per build, the sample index taken in each cycle (-1 = nothing taken).
    int logn_p [2] = '{4, 2};
    int ns_p   [2] = '{3, 2};
    int sl_p   [2] = '{2, 1};
    int pos    [2];
    int hist   [2][64];
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int tag_at(input int i, input int d);
        return hist[i][(cyc - d) & 63];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            pos[i] = -1;
            for (int j = 0; j < 64; j++) hist[i][j] = -1;
        end
    endtask

    task automatic model_step(input logic s, input logic r);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int flen;
            flen = 1 << logn_p[i];
            if (!r) pos[i] = -1;
            else if (s && (pos[i] < 0 || pos[i] == flen - 1)) pos[i] = 0;
            else if (pos[i] >= 0 && pos[i] < flen - 1) pos[i] = pos[i] + 1;
            else pos[i] = -1;
            hist[i][cyc & 63] = pos[i];
        end
    endtask

    task automatic check_inst(input int i, input string nm, input logic take,
                              input logic [2:0] sel, input logic ov, input logic sof,
                              input logic dn, input logic bz);
        int lt, t, flen;
        logic [2:0] e_sel;
        logic e_busy;
        flen  = 1 << logn_p[i];
        lt    = ns_p[i] * sl_p[i];
        e_sel = '0;
        for (int k = 0; k < ns_p[i]; k++) begin
            t = tag_at(i, k * sl_p[i]);
            if (t >= 0) e_sel[k] = 1'((t >> (logn_p[i] - 1 - k)) & 1);
        end
        e_busy = 1'b0;
        for (int d = 0; d <= lt; d++) if (tag_at(i, d) >= 0) e_busy = 1'b1;
        t = tag_at(i, lt);
        check({nm, ".in_take"},   32'(take), 32'(tag_at(i, 0) >= 0));
        check({nm, ".sel"},       32'(sel),  32'(e_sel));
        check({nm, ".out_valid"}, 32'(ov),   32'(t >= 0));
        check({nm, ".out_sof"},   32'(sof),  32'(t == 0));
        check({nm, ".done"},      32'(dn),   32'(t == flen - 1));
        check({nm, ".busy"},      32'(bz),   32'(e_busy));
    endtask

    task automatic check_all();
        check_inst(0, "A", bus_a.in_take, bus_a.sel, bus_a.out_valid,
                   bus_a.out_sof, bus_a.done, bus_a.busy);
        check_inst(1, "B", bus_b.in_take, {1'b0, bus_b.sel}, bus_b.out_valid,
                   bus_b.out_sof, bus_b.done, bus_b.busy);
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge,
    // compare shortly after. A falling rst_n is also checked for its async effect.
    task automatic tick(input logic s, input logic r);
        logic was;
        @(negedge clk);
        was   = rst_n;
        rst_n = r;
        start = s;
        if (was && !r) begin
            #1;
            check("A.rst_async", {bus_a.in_take, 3'(bus_a.sel), bus_a.out_valid,
                                  bus_a.out_sof, bus_a.done, bus_a.busy}, '0);
            check("B.rst_async", {bus_b.in_take, 2'(bus_b.sel), bus_b.out_valid,
                                  bus_b.out_sof, bus_b.done, bus_b.busy}, '0);
            clear_model();
        end
        @(posedge clk);
        model_step(s, r);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cyc   = 100;
        clear_model();
        repeat (3) tick(1'b0, 1'b0);
        idle(50);                                   // never started
        tick(1'b1, 1'b1); idle(30);                 // single frame
        tick(1'b1, 1'b1); idle(15);                 // back-to-back frames
        tick(1'b1, 1'b1); idle(30);
        tick(1'b1, 1'b1); idle(4);                  // start inside a frame
        tick(1'b1, 1'b1); idle(30);
        tick(1'b1, 1'b1); idle(9);                  // reset mid-frame, then restart
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        idle(5);
        tick(1'b1, 1'b1); idle(30);
        for (int n = 0; n < 800; n++) begin
            logic s, r;
            s = ($urandom_range(0, 5) == 0);
            r = !($urandom_range(0, 199) == 0);
            tick(s, r);
        end
        idle(30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
